stage_wb_latch: RTL and testbench
=================================

STAGE_WB_LATCH -- requirements
Module: stage_wb_latch

Interface
REQ-001 SHALL provide: CLK  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL provide: nRST  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: en  input  1  pipeline advance; capture MEM-stage outputs this edge.
REQ-004 SHALL provide: flush  input  1  insert bubble this edge.
REQ-005 SHALL provide: npc_in, aluOut_in, dmemload_in  input  32 each  MEM-stage next PC, ALU result, load/SC-result data.
REQ-006 SHALL provide: memtoReg_in, jal_in, regWrite_in, halt_in  input  1 each  MEM-stage WB controls.
REQ-007 SHALL provide: regSel_in  input  5  destination register.
REQ-008 SHALL provide: wsel  output  5  register-file write select.
REQ-009 SHALL provide: wdat  output  32  register-file write data, also the forwarding source.
REQ-010 SHALL provide: WEN  output  1  register-file write enable.
REQ-011 SHALL provide: valid_out  output  1  latch holds a real instruction (not bubble).
REQ-012 SHALL provide: halt  output  1  sticky core-halted flag.
REQ-013 SHALL provide: retired  output  32  count of instructions latched.

Function
REQ-014 Held state SHALL be: valid, npc, aluOut, dmemload, memtoReg, jal, regWrite, regSel, halt-in bit.
REQ-015 Priority at each edge SHALL be: halt sticky > flush > en > hold.
REQ-016 flush=1 (en don't-care) SHALL load bubble: valid=0, regWrite=0, halt-in bit=0, data fields=0.
REQ-017 en=1, flush=0 SHALL capture all *_in fields; valid=1.
REQ-018 en=0, flush=0 SHALL hold all state unchanged (stall).
REQ-019 Latency SHALL be one cycle: inputs at edge N visible on wsel/wdat/WEN after edge N, no combinational input-to-output path.
REQ-020 wdat SHALL be combinational from held state: jal ? npc : (memtoReg ? dmemload : aluOut).
REQ-021 wsel SHALL equal held regSel, except when held jal=1 it SHALL be 5'd31.
REQ-022 WEN SHALL be valid & regWrite & ~halt & (wsel != 0).
REQ-023 halt SHALL set at the edge that captures halt_in=1 with en=1, flush=0, and SHALL remain 1 until nRST.
REQ-024 While halt=1, captures SHALL be ignored (state frozen) and WEN SHALL be 0, including the halting instruction itself.
REQ-025 retired SHALL increment by 1 at each edge performing a capture (REQ-017) while halt=0, including the halting instruction.
REQ-026 retired SHALL saturate at 32'hFFFFFFFF; no wrap.
REQ-027 Bubbles and stalls SHALL NOT change retired.
REQ-028 Registers SHALL NOT have X-dependent outputs; all fields defined from reset.

Reset
REQ-029 nRST=0 SHALL immediately (asynchronously) clear all held fields, valid, halt and retired to 0.
REQ-030 Consequently during and after reset: wsel=0, wdat=0, WEN=0, valid_out=0, halt=0, retired=0.
REQ-031 Reset asserted mid-stall or after halt SHALL clear state identically; first edge after release obeys REQ-015.

Verification
REQ-032 Scenario ALU write: en=1, regWrite=1, regSel=8, aluOut=0x1234, memtoReg=0, jal=0 -> next cycle wsel=8, wdat=0x1234, WEN=1, retired=1.
REQ-033 Scenario load + stall: en=1, memtoReg=1, dmemload=0xDEADBEEF, regSel=9; then en=0 for 3 cycles with inputs changed -> wdat=0xDEADBEEF, wsel=9 held all 3 cycles, retired stays 1.
REQ-034 Scenario JAL and $0: en=1, jal=1, npc=0x40, regSel=0, regWrite=1 -> wsel=31, wdat=0x40, WEN=1; then regSel=0, jal=0, regWrite=1 -> WEN=0, retired increments both times.
REQ-035 Scenario flush priority: en=1, flush=1, regWrite=1, regSel=5 -> valid_out=0, WEN=0, retired unchanged.
REQ-036 Scenario halt: en=1, halt_in=1, regWrite=1, regSel=4 -> halt=1, WEN=0; further en=1 captures with regWrite=1 -> WEN=0, retired frozen; pulse nRST low mid-cycle -> all outputs 0 immediately.
REQ-037 Scenario saturation: force retired to 32'hFFFFFFFE, two captures -> retired=32'hFFFFFFFF after both, no wrap.

Source files
------------

// File: rtl/stage_wb_latch_if.sv
// MEM->WB pipeline latch bus: MEM-stage results and WB controls going in,
// register-file write port, retirement and halt status coming out.
interface stage_wb_latch_if;
   // pipeline control
   logic        en;
   logic        flush;
   // MEM-stage results
   logic [31:0] npc_in;
   logic [31:0] aluOut_in;
   logic [31:0] dmemload_in;
   // MEM-stage writeback controls
   logic        memtoReg_in;
   logic        jal_in;
   logic        regWrite_in;
   logic        halt_in;
   logic [4:0]  regSel_in;
   // register-file write port and status
   logic [4:0]  wsel;
   logic [31:0] wdat;
   logic        WEN;
   logic        valid_out;
   logic        halt;
   logic [31:0] retired;

   // MEM stage side: drives the captured fields, observes writeback
   modport master (
      output en, flush, npc_in, aluOut_in, dmemload_in,
             memtoReg_in, jal_in, regWrite_in, halt_in, regSel_in,
      input  wsel, wdat, WEN, valid_out, halt, retired
   );

   // latch side
   modport slave (
      input  en, flush, npc_in, aluOut_in, dmemload_in,
             memtoReg_in, jal_in, regWrite_in, halt_in, regSel_in,
      output wsel, wdat, WEN, valid_out, halt, retired
   );
endinterface

// File: rtl/stage_wb_latch.sv
// MEM/WB pipeline latch. Holds the MEM-stage result for one cycle and presents
// the register-file write port. Stall holds, flush inserts a bubble, and a
// captured halt freezes the latch until reset. The write-port outputs are
// computed from the next held state and registered, so they carry exactly the
// value the held fields imply with no path from the inputs.
module stage_wb_latch (
   input  logic            CLK,
   input  logic            nRST,
   stage_wb_latch_if.slave bus
);

   localparam logic [4:0]  LINK_REG    = 5'd31;
   localparam logic [4:0]  ZERO_REG    = 5'd0;
   localparam logic [31:0] RETIRED_MAX = 32'hFFFF_FFFF;

   // held instruction fields
   logic        valid_r;
   logic [31:0] npc_r;
   logic [31:0] alu_out_r;
   logic [31:0] dmemload_r;
   logic        mem_to_reg_r;
   logic        jal_r;
   logic        reg_write_r;
   logic [4:0]  reg_sel_r;
   logic        halt_in_r;

   // core status
   logic        halt_r;
   logic [31:0] retired_r;

   // registered write port
   logic [4:0]  wsel_r;
   logic [31:0] wdat_r;
   logic        wen_r;

   // next-state values
   logic        capture_s;
   logic        bubble_s;
   logic        valid_nxt_s;
   logic [31:0] npc_nxt_s;
   logic [31:0] alu_out_nxt_s;
   logic [31:0] dmemload_nxt_s;
   logic        mem_to_reg_nxt_s;
   logic        jal_nxt_s;
   logic        reg_write_nxt_s;
   logic [4:0]  reg_sel_nxt_s;
   logic        halt_in_nxt_s;
   logic        halt_nxt_s;
   logic [31:0] retired_nxt_s;
   logic [4:0]  wsel_nxt_s;
   logic [31:0] wdat_nxt_s;
   logic        wen_nxt_s;

   // Edge action: a halted core ignores everything, then flush beats advance.
   always_comb begin
      capture_s = 1'b0;
      bubble_s  = 1'b0;
      if (halt_r) begin
         capture_s = 1'b0;
         bubble_s  = 1'b0;
      end else if (bus.flush) begin
         bubble_s  = 1'b1;
      end else if (bus.en) begin
         capture_s = 1'b1;
      end else begin
         capture_s = 1'b0;
         bubble_s  = 1'b0;
      end
   end

   // Next held fields: bubble zeroes everything, capture copies, otherwise hold.
   always_comb begin
      valid_nxt_s      = valid_r;
      npc_nxt_s        = npc_r;
      alu_out_nxt_s    = alu_out_r;
      dmemload_nxt_s   = dmemload_r;
      mem_to_reg_nxt_s = mem_to_reg_r;
      jal_nxt_s        = jal_r;
      reg_write_nxt_s  = reg_write_r;
      reg_sel_nxt_s    = reg_sel_r;
      halt_in_nxt_s    = halt_in_r;
      if (bubble_s) begin
         valid_nxt_s      = 1'b0;
         npc_nxt_s        = 32'd0;
         alu_out_nxt_s    = 32'd0;
         dmemload_nxt_s   = 32'd0;
         mem_to_reg_nxt_s = 1'b0;
         jal_nxt_s        = 1'b0;
         reg_write_nxt_s  = 1'b0;
         reg_sel_nxt_s    = 5'd0;
         halt_in_nxt_s    = 1'b0;
      end else if (capture_s) begin
         valid_nxt_s      = 1'b1;
         npc_nxt_s        = bus.npc_in;
         alu_out_nxt_s    = bus.aluOut_in;
         dmemload_nxt_s   = bus.dmemload_in;
         mem_to_reg_nxt_s = bus.memtoReg_in;
         jal_nxt_s        = bus.jal_in;
         reg_write_nxt_s  = bus.regWrite_in;
         reg_sel_nxt_s    = bus.regSel_in;
         halt_in_nxt_s    = bus.halt_in;
      end else begin
         valid_nxt_s      = valid_r;
      end
   end

   // Sticky halt and saturating retirement counter; the halting capture still counts.
   always_comb begin
      halt_nxt_s    = halt_r | (capture_s & bus.halt_in);
      retired_nxt_s = retired_r;
      if (capture_s && (retired_r != RETIRED_MAX)) begin
         retired_nxt_s = retired_r + 32'd1;
      end else begin
         retired_nxt_s = retired_r;
      end
   end

   // Write port implied by the next held state: JAL links to r31, r0 never written.
   always_comb begin
      wsel_nxt_s = reg_sel_nxt_s;
      wdat_nxt_s = alu_out_nxt_s;
      if (jal_nxt_s) begin
         wsel_nxt_s = LINK_REG;
         wdat_nxt_s = npc_nxt_s;
      end else if (mem_to_reg_nxt_s) begin
         wsel_nxt_s = reg_sel_nxt_s;
         wdat_nxt_s = dmemload_nxt_s;
      end else begin
         wsel_nxt_s = reg_sel_nxt_s;
         wdat_nxt_s = alu_out_nxt_s;
      end
      wen_nxt_s = valid_nxt_s & reg_write_nxt_s & ~halt_nxt_s & (wsel_nxt_s != ZERO_REG);
   end

   // State and output registers, cleared asynchronously by nRST.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_r      <= 1'b0;
         npc_r        <= 32'd0;
         alu_out_r    <= 32'd0;
         dmemload_r   <= 32'd0;
         mem_to_reg_r <= 1'b0;
         jal_r        <= 1'b0;
         reg_write_r  <= 1'b0;
         reg_sel_r    <= 5'd0;
         halt_in_r    <= 1'b0;
         halt_r       <= 1'b0;
         retired_r    <= 32'd0;
         wsel_r       <= 5'd0;
         wdat_r       <= 32'd0;
         wen_r        <= 1'b0;
      end else begin
         valid_r      <= valid_nxt_s;
         npc_r        <= npc_nxt_s;
         alu_out_r    <= alu_out_nxt_s;
         dmemload_r   <= dmemload_nxt_s;
         mem_to_reg_r <= mem_to_reg_nxt_s;
         jal_r        <= jal_nxt_s;
         reg_write_r  <= reg_write_nxt_s;
         reg_sel_r    <= reg_sel_nxt_s;
         halt_in_r    <= halt_in_nxt_s;
         halt_r       <= halt_nxt_s;
         retired_r    <= retired_nxt_s;
         wsel_r       <= wsel_nxt_s;
         wdat_r       <= wdat_nxt_s;
         wen_r        <= wen_nxt_s;
      end
   end

   assign bus.wsel      = wsel_r;
   assign bus.wdat      = wdat_r;
   assign bus.WEN       = wen_r;
   assign bus.valid_out = valid_r;
   assign bus.halt      = halt_r;
   assign bus.retired   = retired_r;

endmodule

// File: tb/tb_stage_wb_latch.sv
// Self-checking bench for stage_wb_latch: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model that
// tracks the latched instruction as (destination, value) plus a capture count.
module tb_stage_wb_latch;

   logic clk = 1'b0;
   logic nrst;

   stage_wb_latch_if wb_if ();

   stage_wb_latch dut (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (wb_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // behavioural model of the latched instruction
   logic        m_valid;
   logic [4:0]  m_dest;
   logic [31:0] m_val;
   logic        m_rw;
   logic        m_halt;
   logic [63:0] m_count;
   logic [63:0] bias = 64'd0;   // preload used by the saturation scenario

   // Model: halted core is frozen, else flush bubbles, else en captures.
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_valid <= 1'b0;
         m_dest  <= 5'd0;
         m_val   <= 32'd0;
         m_rw    <= 1'b0;
         m_halt  <= 1'b0;
         m_count <= 64'd0;
      end else if (!m_halt) begin
         if (wb_if.flush) begin
            m_valid <= 1'b0;
            m_dest  <= 5'd0;
            m_val   <= 32'd0;
            m_rw    <= 1'b0;
         end else if (wb_if.en) begin
            m_valid <= 1'b1;
            m_dest  <= wb_if.jal_in ? 5'd31 : wb_if.regSel_in;
            m_val   <= wb_if.jal_in ? wb_if.npc_in :
                       (wb_if.memtoReg_in ? wb_if.dmemload_in : wb_if.aluOut_in);
            m_rw    <= wb_if.regWrite_in;
            m_count <= m_count + 64'd1;
            if (wb_if.halt_in) m_halt <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic compare_all();
      logic [63:0] tot;
      logic [31:0] exp_ret;
      logic        exp_wen;
      tot     = m_count + bias;
      exp_ret = (tot >= 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : tot[31:0];
      exp_wen = m_valid && m_rw && !m_halt && (m_dest != 5'd0);
      chk("wsel",      {27'd0, wb_if.wsel},      {27'd0, m_dest});
      chk("wdat",      wb_if.wdat,               m_val);
      chk("WEN",       {31'd0, wb_if.WEN},       {31'd0, exp_wen});
      chk("valid_out", {31'd0, wb_if.valid_out}, {31'd0, m_valid});
      chk("halt",      {31'd0, wb_if.halt},      {31'd0, m_halt});
      chk("retired",   wb_if.retired,            exp_ret);
   endtask

   task automatic zero_inputs();
      wb_if.en          = 1'b0;
      wb_if.flush       = 1'b0;
      wb_if.npc_in      = 32'd0;
      wb_if.aluOut_in   = 32'd0;
      wb_if.dmemload_in = 32'd0;
      wb_if.memtoReg_in = 1'b0;
      wb_if.jal_in      = 1'b0;
      wb_if.regWrite_in = 1'b0;
      wb_if.halt_in     = 1'b0;
      wb_if.regSel_in   = 5'd0;
   endtask

   // One clock: drive at the falling edge, check after the rising edge.
   task automatic step(input logic e, input logic f, input logic [31:0] npc,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic m2r, input logic j, input logic rw,
                       input logic h, input logic [4:0] sel);
      @(negedge clk);
      wb_if.en          = e;
      wb_if.flush       = f;
      wb_if.npc_in      = npc;
      wb_if.aluOut_in   = alu;
      wb_if.dmemload_in = dm;
      wb_if.memtoReg_in = m2r;
      wb_if.jal_in      = j;
      wb_if.regWrite_in = rw;
      wb_if.halt_in     = h;
      wb_if.regSel_in   = sel;
      @(posedge clk);
      #1 compare_all();
   endtask

   // Mid-cycle asynchronous reset; outputs must clear immediately.
   task automatic apply_reset();
      @(negedge clk);
      #2;
      nrst = 1'b0;
      bias = 64'd0;
      zero_inputs();
      #1;
      chk("rst wsel",    {27'd0, wb_if.wsel},      32'd0);
      chk("rst wdat",    wb_if.wdat,               32'd0);
      chk("rst WEN",     {31'd0, wb_if.WEN},       32'd0);
      chk("rst valid",   {31'd0, wb_if.valid_out}, 32'd0);
      chk("rst halt",    {31'd0, wb_if.halt},      32'd0);
      chk("rst retired", wb_if.retired,            32'd0);
      compare_all();
      @(negedge clk);
      nrst = 1'b1;
   endtask

   initial begin
      nrst = 1'b0;
      zero_inputs();
      #7;
      chk("init wsel",    {27'd0, wb_if.wsel}, 32'd0);
      chk("init WEN",     {31'd0, wb_if.WEN},  32'd0);
      chk("init retired", wb_if.retired,       32'd0);
      compare_all();
      @(negedge clk);
      nrst = 1'b1;

      // ALU write
      step(1'b1, 1'b0, 32'h0, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8);
      chk("alu wsel",    {27'd0, wb_if.wsel}, 32'd8);
      chk("alu wdat",    wb_if.wdat,          32'h1234);
      chk("alu WEN",     {31'd0, wb_if.WEN},  32'd1);
      chk("alu retired", wb_if.retired,       32'd1);

      // load then three stall cycles with changing inputs
      apply_reset();
      step(1'b1, 1'b0, 32'h0, 32'h55, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 5'($urandom));
         chk("stall wdat",    wb_if.wdat,          32'hDEADBEEF);
         chk("stall wsel",    {27'd0, wb_if.wsel}, 32'd9);
         chk("stall retired", wb_if.retired,       32'd1);
      end

      // JAL links to r31 even with regSel=0, then a write to r0 is suppressed
      apply_reset();
      step(1'b1, 1'b0, 32'h40, 32'h77, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
      chk("jal wsel",    {27'd0, wb_if.wsel}, 32'd31);
      chk("jal wdat",    wb_if.wdat,          32'h40);
      chk("jal WEN",     {31'd0, wb_if.WEN},  32'd1);
      chk("jal retired", wb_if.retired,       32'd1);
      step(1'b1, 1'b0, 32'h44, 32'h99, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      chk("r0 WEN",     {31'd0, wb_if.WEN}, 32'd0);
      chk("r0 retired", wb_if.retired,      32'd2);

      // flush beats en
      step(1'b1, 1'b1, 32'h0, 32'h12, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
      chk("flush valid",   {31'd0, wb_if.valid_out}, 32'd0);
      chk("flush WEN",     {31'd0, wb_if.WEN},       32'd0);
      chk("flush retired", wb_if.retired,            32'd2);

      // halt is sticky, suppresses writes, freezes the counter
      apply_reset();
      step(1'b1, 1'b0, 32'h0, 32'h21, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4);
      chk("halt halt",    {31'd0, wb_if.halt}, 32'd1);
      chk("halt WEN",     {31'd0, wb_if.WEN},  32'd0);
      chk("halt retired", wb_if.retired,       32'd1);
      step(1'b1, 1'b0, 32'h0, 32'h22, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7);
      chk("halted WEN",     {31'd0, wb_if.WEN}, 32'd0);
      chk("halted retired", wb_if.retired,      32'd1);
      step(1'b1, 1'b1, 32'h0, 32'h23, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6);
      chk("halted frozen wdat", wb_if.wdat, 32'h21);
      apply_reset();

      // saturation of the retirement counter
      step(1'b1, 1'b0, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
      #2;
      force dut.retired_r = 32'hFFFF_FFFE;
      bias = 64'h0000_0000_FFFF_FFFE - m_count;
      #1;
      release dut.retired_r;
      chk("sat preload", wb_if.retired, 32'hFFFF_FFFE);
      step(1'b1, 1'b0, 32'h0, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
      chk("sat first", wb_if.retired, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, 32'h0, 32'h3, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
      chk("sat second", wb_if.retired, 32'hFFFF_FFFF);
      apply_reset();

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            apply_reset();
         end else begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom, $urandom, $urandom,
                 1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0, 5'($urandom));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
